// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence generator.
// State encoding, default widths and the reference test word.
package seq_pkg;

    localparam int SEQ_DATA_W = 24;
    localparam int SEQ_LEN_W  = 5;

    localparam logic [SEQ_DATA_W-1:0] SEQ_TEST_WORD = 24'h0C9094;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_ser_gen.sv
// Parallel-to-serial MSB-first frame generator for the sequence detector.
// Optional frame looping is enabled with `define SEQ_SER_GEN_LOOP_EN.
module seq_ser_gen
    import seq_pkg::*;
#(
    parameter int DATA_W     = SEQ_DATA_W,
    parameter int LEN_W      = SEQ_LEN_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic [LEN_W-1:0]  in_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    output logic              ser_last,
    output logic              busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LEN_W-1:0] CNT_MAX = LEN_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef SEQ_SER_GEN_LOOP_EN
    localparam bit RELOAD_ON_LAST = 1'b1;
`else
    localparam bit RELOAD_ON_LAST = (GAP_CYCLES == 0);
`endif

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [LEN_W-1:0]  load_cnt;
    logic              last_bit;
    logic              accept;

`ifdef SEQ_SER_GEN_LOOP_EN
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [LEN_W-1:0]  hold_cnt_q, hold_cnt_d;
`endif

    // Zero or oversize lengths both mean a full-width frame.
    always_comb begin
        load_cnt = CNT_MAX;
        if (in_len != '0 && 32'(in_len) <= 32'(DATA_W)) begin
            load_cnt = in_len - 1'b1;
        end
    end

    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == '0);

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_IDLE:  in_ready = 1'b1;
                ST_SHIFT: in_ready = RELOAD_ON_LAST && (cnt_q == '0);
                ST_GAP:   in_ready = 1'b0;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
`ifdef SEQ_SER_GEN_LOOP_EN
        hold_data_d = hold_data_q;
        hold_cnt_d  = hold_cnt_q;
        if (accept) begin
            hold_data_d = in_data;
            hold_cnt_d  = load_cnt;
        end
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sreg_d  = in_data;
                    cnt_d   = load_cnt;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d = sreg_q << 1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    if (accept) begin
                        sreg_d = in_data;
                        cnt_d  = load_cnt;
`ifdef SEQ_SER_GEN_LOOP_EN
                    end else begin
                        sreg_d = hold_data_q;
                        cnt_d  = hold_cnt_q;
                    end
`else
                    end else if (GAP_CYCLES > 0) begin
                        cnt_d   = '0;
                        gap_d   = GAP_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
        end
    end

`ifdef SEQ_SER_GEN_LOOP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data_q <= '0;
            hold_cnt_q  <= '0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end
`endif

    // Serial outputs depend only on registered state.
    assign ser_valid = (state_q == ST_SHIFT);
    assign ser_bit   = ser_valid & sreg_q[DATA_W-1];
    assign ser_last  = last_bit;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_ser_gen.sv
// Randomised bench for seq_ser_gen: two instances (no gap, gap of 3)
// checked every cycle against a bit-queue transaction model.
module tb_seq_ser_gen;
    import seq_pkg::*;

    localparam int DW = 24;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    iv;
    logic [DW-1:0] idat [2];
    logic [LW-1:0] ilen [2];
    logic [1:0]    ordy, obit, oval, olast, obusy;

    seq_ser_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_data(idat[0]), .in_len(ilen[0]), .in_valid(iv[0]),
        .in_ready(ordy[0]), .ser_bit(obit[0]), .ser_valid(oval[0]),
        .ser_last(olast[0]), .busy(obusy[0])
    );

    seq_ser_gen #(.DATA_W(DW), .LEN_W(LW), .GAP_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_data(idat[1]), .in_len(ilen[1]), .in_valid(iv[1]),
        .in_ready(ordy[1]), .ser_bit(obit[1]), .ser_valid(oval[1]),
        .ser_last(olast[1]), .busy(obusy[1])
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Model: pending frame bits (front = bit n-1), idle gap left, hold word.
    logic [63:0]   mbuf [2];
    int            mn   [2];
    int            mgap [2];
    logic [DW-1:0] hw   [2];
    logic [LW-1:0] hl   [2];
    bit            macc [2];

    function automatic int gap_of(input int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic int eff(input logic [LW-1:0] l);
        return (l == 0 || int'(l) > DW) ? DW : int'(l);
    endfunction

    function automatic bit exp_rdy(input int d);
        if (rst) return 1'b0;
`ifdef SEQ_SER_GEN_LOOP_EN
        return mn[d] <= 1;
`else
        return (mn[d] == 0 && mgap[d] == 0) || (gap_of(d) == 0 && mn[d] == 1);
`endif
    endfunction

    task automatic push(input int d, input logic [DW-1:0] data,
                        input logic [LW-1:0] len);
        int l;
        l = eff(len);
        mbuf[d] = (mbuf[d] << l) | (64'(data) >> (DW - l));
        mn[d] += l;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit r [2];
        bit acc, was_last;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rdy%0d", d), 32'(ordy[d]), 32'(exp_rdy(d)));
            check($sformatf("val%0d", d), 32'(oval[d]), 32'(mn[d] > 0));
            check($sformatf("bit%0d", d), 32'(obit[d]),
                  (mn[d] > 0) ? 32'(mbuf[d][mn[d]-1]) : 32'd0);
            check($sformatf("last%0d", d), 32'(olast[d]), 32'(mn[d] == 1));
            check($sformatf("busy%0d", d), 32'(obusy[d]),
                  32'(mn[d] > 0 || mgap[d] > 0));
            r[d] = exp_rdy(d);
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mn[d] = 0; mgap[d] = 0; macc[d] = 0;
                hw[d] = '0; hl[d] = '0;
            end else begin
                acc      = iv[d] && r[d];
                was_last = (mn[d] == 1);
                if (mn[d] > 0) mn[d]--;
                else if (mgap[d] > 0) mgap[d]--;
                if (was_last && !acc) begin
`ifdef SEQ_SER_GEN_LOOP_EN
                    push(d, hw[d], hl[d]);
`else
                    mgap[d] = gap_of(d);
`endif
                end
                if (acc) begin
                    push(d, idat[d], ilen[d]);
                    hw[d] = idat[d];
                    hl[d] = ilen[d];
                end
                macc[d] = acc;
            end
        end
        #1;
        cyc++;
    endtask

    task automatic send(input int d, input logic [DW-1:0] data,
                        input logic [LW-1:0] len);
        idat[d] = data;
        ilen[d] = len;
        iv[d]   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            step();
            if (macc[d]) break;
        end
        check($sformatf("accept%0d", d), 32'(macc[d]), 32'd1);
    endtask

    task automatic drain(input int d);
        iv[d] = 1'b0;
`ifdef SEQ_SER_GEN_LOOP_EN
        repeat (30) step();
`else
        for (int k = 0; k < 100; k++) begin
            if (mn[d] == 0 && mgap[d] == 0) break;
            step();
        end
        check($sformatf("drain%0d", d), 32'(mn[d] + mgap[d]), 32'd0);
`endif
    endtask

    initial begin
        rst = 1'b1;
        iv  = '0;
        for (int d = 0; d < 2; d++) begin
            idat[d] = '0; ilen[d] = '0; mbuf[d] = '0;
            mn[d] = 0; mgap[d] = 0; hw[d] = '0; hl[d] = '0; macc[d] = 0;
        end
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;
        step();

        send(0, SEQ_TEST_WORD, 5'd0);
        drain(0);
        send(0, 24'hA00000, 5'd4);
        drain(0);
        send(0, 24'h800000, 5'd1);
        drain(0);
        send(0, 24'h5A5A5A, 5'd30);
        drain(0);

        send(0, 24'hFFFFFF, 5'd0);
        send(0, 24'h000000, 5'd0);
        drain(0);

        send(1, SEQ_TEST_WORD, 5'd4);
        send(1, 24'hC00000, 5'd2);
        drain(1);

        idat[0] = SEQ_TEST_WORD; ilen[0] = 5'd0;
        idat[1] = 24'hF0F0F0;    ilen[1] = 5'd24;
        iv = 2'b11;
        step();
        iv = 2'b00;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send(0, 24'h3C3C3C, 5'd8);
        drain(0);
        send(1, 24'h812345, 5'd0);
        drain(1);

        for (int c = 0; c < 1500; c++) begin
            for (int d = 0; d < 2; d++) begin
                if (!iv[d] && $urandom_range(2) == 0) begin
                    iv[d]   = 1'b1;
                    idat[d] = DW'($urandom);
                    ilen[d] = LW'($urandom);
                end
            end
            rst = ($urandom_range(99) == 0);
            step();
            for (int d = 0; d < 2; d++) begin
                if (macc[d]) iv[d] = 1'b0;
            end
        end
        rst = 1'b0;
        drain(0);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_ser_gen.md
Name: seq_ser_gen

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and serialises each one MSB-first onto a 1-bit stream (`ser_bit`), which drives the detector's serial data input directly.
- Supports variable frame length, optional idle gap between frames, and back-to-back streaming, so the detector sees continuous or gapped bitstreams.

Parameters:
- DATA_W, 24, width of parallel input word and shift register.
- LEN_W, 5, width of the frame-length field; must satisfy 2^LEN_W >= DATA_W.
- GAP_CYCLES, 0, idle cycles inserted after each frame's last bit (0 = none).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  parallel word; bit DATA_W-1 is transmitted first.
- in_len  input  LEN_W  number of bits to send, counted from MSB; 0 or >DATA_W is treated as DATA_W.
- in_valid  input  1  word/length valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_bit  output  1  serial data bit to the detector.
- ser_valid  output  1  `ser_bit` carries frame data this cycle.
- ser_last  output  1  current bit is the final bit of the frame.
- busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset (decided): one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset state: state=IDLE, shift register=0, bit counter=0, gap counter=0.
- Output values during reset: `ser_bit`=0, `ser_valid`=0, `ser_last`=0, `busy`=0, `in_ready`=0.
- `rst` overrides everything, including a mid-frame transfer; the partial frame is discarded, not resumed.
- `in_ready` goes to 1 on the first cycle after `rst` deasserts.
- State machine: IDLE, SHIFT, GAP.
  - IDLE: `in_ready`=1. When `in_valid`&`in_ready`, on that edge: sreg<=in_data, cnt<=eff_len-1, state<=SHIFT. The first bit appears the cycle after acceptance (1-cycle latency).
  - SHIFT:
    - `ser_valid`=1; `ser_bit`=sreg[DATA_W-1]; `ser_last`=(cnt==0).
    - Each edge: sreg<=sreg<<1 (zero fill), cnt<=cnt-1.
    - When cnt==0: go to GAP (gap counter loaded with GAP_CYCLES-1) if GAP_CYCLES>0, else to IDLE.
  - Back-to-back: if GAP_CYCLES==0, `in_ready`=1 during the last SHIFT bit. A handshake then reloads sreg/cnt and stays in SHIFT, so the stream has no bubble.
  - GAP: `ser_valid`=0, `ser_bit`=0, `in_ready`=0. Counts down, then goes to IDLE.
- Outputs in IDLE: `ser_bit`=0, `ser_valid`=0.
- `ser_bit` is driven from a register, with no combinational path from inputs.
- eff_len=1: a single-cycle frame with `ser_valid` and `ser_last` both high.
- `in_valid` asserted while `in_ready`=0 is ignored. The source must hold its data until the handshake completes.

Optional Feature:
- Macro: SEQ_SER_GEN_LOOP_EN.
- When defined:
  - The accepted word and length are also stored in a hold register.
  - On the last bit, if no new handshake occurs, the hold word is reloaded and the frame repeats indefinitely, ignoring GAP_CYCLES. This gives continuous rotation for long detector soak runs.
  - A new handshake while looping replaces the word at the next frame boundary; `in_ready` is 1 only on the last bit.
  - `rst` clears the hold register and ends looping.
- When undefined: no hold register; behaviour is exactly as described above.

Decomposition:
- Shared package `seq_pkg`:
  - State encoding constants ST_IDLE/ST_SHIFT/ST_GAP (2-bit).
  - Default DATA_W/LEN_W.
  - Reference test word constant SEQ_TEST_WORD=24'h0C9094.
- Single module; no sub-module needed. A separate down-counter for GAP is small enough to stay inline.

Test Plan:
- Reset then accept in_data=24'h0C9094, in_len=0 (treated as 24): `ser_bit` sequence 0000_1100_1001_0000_1001_0100 over 24 cycles starting the cycle after handshake. `ser_last` high on the 24th bit only, then IDLE.
- in_len=4, in_data=24'hA00000: bits 1,0,1,0 with `ser_last` on the 4th. in_len=1: single-cycle frame with `ser_valid`=`ser_last`=1.
- GAP_CYCLES=0, `in_valid` held high with two words 24'hFFFFFF then 24'h000000: 48 contiguous valid bits, no bubble, `in_ready` pulsing on each last bit.
- GAP_CYCLES=3: after `ser_last`, exactly 3 cycles with `ser_valid`=0 and `in_ready`=0, then `in_ready`=1.
- Assert `rst` at bit 10 of a 24-bit frame: the next cycle has all outputs 0 and state IDLE; the following frame starts cleanly from its MSB.
- With SEQ_SER_GEN_LOOP_EN, load 24'h0C9094 once: the stream repeats with period 24 for at least 3 frames. A second word is accepted only at a `ser_last` cycle and takes effect in the following frame.
